boot_rom_overlay: RTL
=====================

Name: boot_rom_overlay

Overview:
- Sits between the CPU memory port and the downstream system bus.
- While boot mode is active, CPU reads at 0x0000–0x00FF are served from the 256x8 boot pROM; every other access goes to the system bus.
- A CPU write of any value with bit0=1 to 0xFF50 permanently leaves boot mode until the next reset.
- Provides one request/acknowledge handshake to the CPU regardless of which side services the access.

Parameters:
- BOOT_BASE, 16'h0000, first address overlaid by the boot ROM.
- BOOT_SIZE_LOG2, 8, overlay size as log2 bytes; must match the pROM depth (256).
- DISABLE_ADDR, 16'hFF50, address of the boot-disable register.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  16  CPU address; stable while cpu_req is high.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  read data; valid in the cpu_ack cycle.
- cpu_ack  out  1  one-cycle completion pulse.
- rom_ad  out  8  pROM address.
- rom_ce  out  1  pROM clock enable.
- rom_oce  out  1  pROM output clock enable; tied 1.
- rom_reset  out  1  pROM synchronous reset; equals ~reset_n.
- rom_dout  in  8  pROM data; valid the cycle after the clk edge that sampled rom_ce=1.
- bus_req  out  1  downstream request.
- bus_we  out  1  downstream write strobe.
- bus_addr  out  16  downstream address.
- bus_wdata  out  8  downstream write data.
- bus_rdata  in  8  downstream read data.
- bus_ack  in  1  downstream completion pulse.
- boot_active  out  1  1 while the overlay is enabled.

Behaviour:
- Reset values: boot_active=1, cpu_ack=0, cpu_rdata=8'h00, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rom_ce=0, rom_ad=0, FSM=IDLE.
- Overlay hit = boot_active & ~cpu_we & (cpu_addr[15:8]==BOOT_BASE[15:8]).
- Disable hit = cpu_addr==DISABLE_ADDR. Both decodes are taken in IDLE, in the cycle the request is accepted.
- FSM states: IDLE, ROM_RD, ROM_DATA, REG_ACK, BUS_WAIT, DONE.
- IDLE, cpu_req=1, choose in priority order:
  - overlay hit -> ROM_RD; rom_ce=1 and rom_ad=cpu_addr[7:0] in that same cycle.
  - disable hit -> REG_ACK.
  - otherwise -> BUS_WAIT; bus_req/bus_we/bus_addr/bus_wdata registered from the CPU signals.
- ROM_RD -> ROM_DATA: rom_ce=0 and rom_dout is valid. Capture cpu_rdata=rom_dout and pulse cpu_ack in ROM_DATA.
- ROM read latency: acceptance edge +2 clocks to cpu_ack.
- REG_ACK, write: if cpu_wdata[0]=1, clear boot_active (sticky). cpu_ack in this cycle; the write is not forwarded to the bus.
- REG_ACK, read: cpu_rdata={7'h7F, ~boot_active}. cpu_ack in this cycle.
- BUS_WAIT:
  - Hold bus_* stable until bus_ack.
  - On bus_ack: drop bus_req, latch cpu_rdata=bus_rdata on reads, pulse cpu_ack in the same cycle.
  - No timeout.
- DONE (after any cpu_ack) -> IDLE. This gives one idle cycle so the CPU can drop cpu_req; a still-high cpu_req in DONE is ignored.
- Writes into the overlay range while boot_active are not overlay hits; they go to the bus (cartridge MBC registers).
- boot_active only changes in REG_ACK, so an in-flight ROM read always completes from the ROM.
- reset_n low mid-transaction:
  - Immediately forces all reset values, including bus_req=0.
  - A pending bus transaction is abandoned; a later stray bus_ack in IDLE is ignored.
  - boot_active returns to 1.
- Address decode is on cpu_addr[15:8], so 0x00FF hits and 0x0100 misses.

Decomposition:
- Shared package boot_pkg:
  - FSM state enum.
  - BOOT_BASE and DISABLE_ADDR constants.
  - Read-back constant 7'h7F.
- No sub-module: the decode and FSM sit in one module.
- fast_boot_prom is instantiated by the parent, not inside this block.

Test Plan:
- After reset, read 0x0000 -> rom_ce=1 with rom_ad=8'h00 in the accept cycle; cpu_ack two clocks later; cpu_rdata equals the pROM model byte 8'h06; bus_req never asserts.
- Read 0x00FF, then 0x0100 -> first served by the ROM with rom_ad=8'hFF; second gives bus_req=1 with bus_addr=16'h0100; bus_rdata=8'hC3 with bus_ack after 3 cycles -> cpu_rdata=8'hC3.
- Write 8'h01 to 0xFF50 -> cpu_ack one cycle after accept; no bus_req; boot_active=0. Re-read 0x0000 -> goes to the bus.
- Write 8'h00 to 0xFF50 -> boot_active stays 1. Read 0xFF50 -> 8'hFE. After a write of 8'h01, read 0xFF50 -> 8'hFF.
- Write 8'h0A to 0x0000 while boot_active -> forwarded with bus_we=1 and bus_wdata=8'h0A; the ROM is not accessed.
- After boot disable, assert reset_n=0 mid BUS_WAIT -> bus_req drops asynchronously and boot_active=1. Release reset, issue a stray bus_ack -> no cpu_ack.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the boot ROM overlay: FSM encoding, default
// address map constants and the boot-disable register read-back pattern.
package boot_pkg;

    // Default overlay base; only the bits above the overlay size are decoded.
    localparam logic [15:0] BootBaseDefault     = 16'h0000;
    // Overlay size as log2 bytes; must match the pROM depth.
    localparam int unsigned BootSizeLog2Default = 8;
    // Boot-disable register address.
    localparam logic [15:0] DisableAddrDefault  = 16'hFF50;

    // Upper seven bits returned when the boot-disable register is read.
    localparam logic [6:0]  RegReadbackHi       = 7'h7F;

    typedef enum logic [2:0] {
        StIdle,
        StRomRd,
        StRomData,
        StRegAck,
        StBusWait,
        StDone
    } boot_state_e;

endpackage

// File: rtl/boot_rom_overlay.sv
// Boot ROM overlay between the CPU memory port and the system bus.
// While boot mode is active, CPU reads of the low page are served from the
// external pROM; everything else is forwarded to the bus. A write with bit0=1
// to the disable register drops boot mode until the next reset.
module boot_rom_overlay
    import boot_pkg::*;
#(
    parameter logic [15:0] BOOT_BASE      = BootBaseDefault,
    parameter int unsigned BOOT_SIZE_LOG2 = BootSizeLog2Default,
    parameter logic [15:0] DISABLE_ADDR   = DisableAddrDefault
) (
    input  logic        clk,
    input  logic        reset_n,

    // CPU side
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,

    // pROM side
    output logic [7:0]  rom_ad,
    output logic        rom_ce,
    output logic        rom_oce,
    output logic        rom_reset,
    input  logic [7:0]  rom_dout,

    // System bus side
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack,

    output logic        boot_active
);

    boot_state_e state_q, state_d;

    logic [7:0]  rdata_q, rdata_d;
    logic        boot_active_q, boot_active_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [7:0]  bus_wdata_q, bus_wdata_d;

    logic accept;
    logic overlay_hit;
    logic disable_hit;
    logic bus_done;

    // Decode the incoming request; only meaningful in the accept cycle.
    always_comb begin
        accept      = (state_q == StIdle) && cpu_req;
        // Writes never hit the overlay so mapper register writes reach the bus.
        overlay_hit = boot_active_q && !cpu_we &&
                      (cpu_addr[15:BOOT_SIZE_LOG2] == BOOT_BASE[15:BOOT_SIZE_LOG2]);
        disable_hit = (cpu_addr == DISABLE_ADDR);
        bus_done    = (state_q == StBusWait) && bus_ack;
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    if (overlay_hit) begin
                        state_d = StRomRd;
                    end else if (disable_hit) begin
                        state_d = StRegAck;
                    end else begin
                        state_d = StBusWait;
                    end
                end
            end
            StRomRd:   state_d = StRomData;
            StRomData: state_d = StDone;
            StRegAck:  state_d = StDone;
            StBusWait: begin
                if (bus_ack) begin
                    state_d = StDone;
                end
            end
            // One idle cycle lets the CPU drop cpu_req before a new accept.
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Next-state logic for read data, boot flag and the bus request registers.
    always_comb begin
        rdata_d       = rdata_q;
        boot_active_d = boot_active_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;

        if (accept && !overlay_hit) begin
            if (disable_hit) begin
                // Register read data is ready for the ack cycle that follows.
                if (!cpu_we) begin
                    rdata_d = {RegReadbackHi, ~boot_active_q};
                end
            end else begin
                bus_req_d   = 1'b1;
                bus_we_d    = cpu_we;
                bus_addr_d  = cpu_addr;
                bus_wdata_d = cpu_wdata;
            end
        end

        // pROM output is valid during StRomRd; capture it for the ack cycle.
        if (state_q == StRomRd) begin
            rdata_d = rom_dout;
        end

        // Sticky: only a reset brings boot mode back.
        if ((state_q == StRegAck) && cpu_we && cpu_wdata[0]) begin
            boot_active_d = 1'b0;
        end

        if (bus_done) begin
            bus_req_d = 1'b0;
            bus_we_d  = 1'b0;
            if (!bus_we_q) begin
                rdata_d = bus_rdata;
            end
        end
    end

    // State and datapath registers; reset abandons any bus transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            rdata_q       <= 8'h00;
            boot_active_q <= 1'b1;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 16'h0000;
            bus_wdata_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            rdata_q       <= rdata_d;
            boot_active_q <= boot_active_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
        end
    end

    // Output drive: pROM strobe in the accept cycle, single ack per access.
    always_comb begin
        rom_ce    = accept && overlay_hit;
        rom_ad    = rom_ce ? cpu_addr[7:0] : 8'h00;
        rom_oce   = 1'b1;
        rom_reset = ~reset_n;

        // Bus completions ack in the bus_ack cycle, so pass the data through.
        cpu_ack   = (state_q == StRomData) || (state_q == StRegAck) || bus_done;
        cpu_rdata = (bus_done && !bus_we_q) ? bus_rdata : rdata_q;

        bus_req     = bus_req_q;
        bus_we      = bus_we_q;
        bus_addr    = bus_addr_q;
        bus_wdata   = bus_wdata_q;
        boot_active = boot_active_q;
    end

endmodule
